// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between pc_fetch_unit (master) and instruction memory (slave).
// A request is accepted in any cycle where imem_valid and imem_ready are both high.
interface pc_fetch_unit_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_valid, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_valid, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM (IDLE -> REQ -> EXEC) with trapping of bad jump targets.
// Define PC_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to zero.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          PCSrc,
    input  logic [31:0]         ImmExt,
    input  logic [31:0]         ALUResult,
    input  logic                retire,
    pc_fetch_unit_if.master     imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    output logic                trap,
    output logic [31:0]         bad_addr,
    output logic [31:0]         instret
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_nxt;
    logic [31:0] target;
    logic        target_bad;
    logic        retire_fire;
    logic        fetch_fire;

    assign PCPlus4     = PC + 32'd4;
    assign retire_fire = (state == EXEC) && retire;
    assign fetch_fire  = (state == REQ) && imem.imem_ready;

    // Handshake outputs decode straight from state so an async reset drops them instantly.
    assign imem.imem_valid = (state == REQ);
    assign imem.imem_addr  = PC;
    assign instr_valid     = (state == EXEC);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        target = PCPlus4;
        unique case (PCSrc)
            2'b00:   target = PCPlus4;
            2'b01:   target = PC + ImmExt;
            2'b10:   target = ALUResult & 32'hFFFF_FFFE;
            default: target = PCPlus4;
        endcase
        target_bad = (PCSrc == 2'b11) || (target[1:0] != 2'b00);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem.imem_ready) state_nxt = EXEC;
            EXEC:    if (retire) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC       <= RESET_PC;
            instr    <= NOP;
            trap     <= 1'b0;
            bad_addr <= 32'h0;
        end else begin
            trap <= 1'b0;
            if (fetch_fire) instr <= imem.imem_rdata;
            if (retire_fire) begin
                if (target_bad) begin
                    PC       <= TRAP_VEC;
                    bad_addr <= target;
                    trap     <= 1'b1;
                end else begin
                    PC <= target;
                end
            end
        end
    end

`ifdef PC_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           instret <= 32'h0;
        else if (retire_fire) instret <= instret + 32'd1;
    end
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table of retire vectors chained through the PC,
// plus hand-written wait-state, ignored-retire and asynchronous-reset sequences.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        retire;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        trap;
    logic [31:0] bad_addr;
    logic [31:0] instret;

    pc_fetch_unit_if imem_bus ();

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .retire     (retire),
        .imem       (imem_bus.master),
        .instr      (instr),
        .instr_valid(instr_valid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .trap       (trap),
        .bad_addr   (bad_addr),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef PC_INSTRET_EN
        return 32'(n);
`else
        return 32'h0 + 32'(n) * 32'h0;
`endif
    endfunction

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        trap;
        logic [31:0] bad;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Each row starts from the PC left by the previous row (reset PC = 0).
        vecs[0]  = '{2'b00, 32'h0,         32'h0,         32'h0000_0004, 1'b0, 32'h0};
        vecs[1]  = '{2'b01, 32'h0000_000C, 32'h0,         32'h0000_0010, 1'b0, 32'h0};
        vecs[2]  = '{2'b01, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 1'b0, 32'h0};
        vecs[3]  = '{2'b01, 32'h0000_0018, 32'h0,         32'h0000_0020, 1'b0, 32'h0};
        vecs[4]  = '{2'b10, 32'h0,         32'h0000_0045, 32'h0000_0044, 1'b0, 32'h0};
        vecs[5]  = '{2'b01, 32'hFFFF_FFDC, 32'h0,         32'h0000_0020, 1'b0, 32'h0};
        vecs[6]  = '{2'b01, 32'h0000_0002, 32'h0,         32'h0000_0100, 1'b1, 32'h0000_0022};
        vecs[7]  = '{2'b01, 32'hFFFF_FF20, 32'h0,         32'h0000_0020, 1'b0, 32'h0000_0022};
        vecs[8]  = '{2'b11, 32'h0000_0010, 32'h0000_0080, 32'h0000_0100, 1'b1, 32'h0000_0024};
        vecs[9]  = '{2'b10, 32'h0,         32'h0000_0103, 32'h0000_0100, 1'b1, 32'h0000_0102};
        vecs[10] = '{2'b10, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0, 32'h0000_0102};
        vecs[11] = '{2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 32'h0000_0102};

        rst_n     = 1'b0;
        PCSrc     = 2'b00;
        ImmExt    = 32'h0;
        ALUResult = 32'h0;
        retire    = 1'b0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h0050_0093;

        #12;
        check("rst_pc",          PC,                  32'h0);
        check("rst_instr",       instr,               32'h0000_0013);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_imem_valid",  {31'b0, imem_bus.imem_valid}, 32'h0);
        check("rst_trap",        {31'b0, trap},       32'h0);
        check("rst_bad_addr",    bad_addr,            32'h0);
        check("rst_instret",     instret,             32'h0);
        check("rst_pcplus4",     PCPlus4,             32'h4);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_imem_valid", {31'b0, imem_bus.imem_valid}, 32'h1);
        check("boot_imem_addr",  imem_bus.imem_addr,  32'h0);
        check("boot_instr_hold", instr,               32'h0000_0013);
        @(negedge clk);
        check("boot_instr",       instr,               32'h0050_0093);
        check("boot_instr_valid", {31'b0, instr_valid}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            PCSrc     = vecs[i].src;
            ImmExt    = vecs[i].imm;
            ALUResult = vecs[i].alu;
            retire    = 1'b1;
            imem_bus.imem_rdata = 32'hA000_0000 | 32'(i);
            @(negedge clk);
            check($sformatf("v%0d_pc", i),        PC,                 vecs[i].pc);
            check($sformatf("v%0d_imem_addr", i), imem_bus.imem_addr, vecs[i].pc);
            check($sformatf("v%0d_pcplus4", i),   PCPlus4,            vecs[i].pc + 32'd4);
            check($sformatf("v%0d_trap", i),      {31'b0, trap},      {31'b0, vecs[i].trap});
            check($sformatf("v%0d_bad_addr", i),  bad_addr,           vecs[i].bad);
            check($sformatf("v%0d_ivalid_drop", i), {31'b0, instr_valid}, 32'h0);
            check($sformatf("v%0d_instret", i),   instret,            exp_cnt(i + 1));
            retire = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_trap_clear", i), {31'b0, trap},     32'h0);
            check($sformatf("v%0d_instr", i),     instr,              32'hA000_0000 | 32'(i));
            check($sformatf("v%0d_ivalid", i),    {31'b0, instr_valid}, 32'h1);
        end

        // Wait states: address held, retire ignored outside EXEC.
        PCSrc  = 2'b01;
        ImmExt = 32'h0000_0040;
        retire = 1'b1;
        imem_bus.imem_ready = 1'b0;
        @(negedge clk);
        ImmExt = 32'h0000_0008;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d_addr", k),  imem_bus.imem_addr, 32'h0000_0040);
            check($sformatf("stall%0d_valid", k), {31'b0, imem_bus.imem_valid}, 32'h1);
            check($sformatf("stall%0d_ivalid", k), {31'b0, instr_valid}, 32'h0);
            check($sformatf("stall%0d_instr", k), instr, 32'hA000_000B);
            if (k < 2) @(negedge clk);
        end
        retire = 1'b0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("stall_done_ivalid",  {31'b0, instr_valid}, 32'h1);
        check("stall_done_instr",   instr,   32'h1234_5678);
        check("stall_pc_unchanged", PC,      32'h0000_0040);
        check("stall_instret",      instret, exp_cnt(13));

        // Asynchronous reset in the 2nd wait-state cycle.
        PCSrc  = 2'b00;
        retire = 1'b1;
        imem_bus.imem_ready = 1'b0;
        @(negedge clk);
        retire = 1'b0;
        check("pre_rst_addr", imem_bus.imem_addr, 32'h0000_0044);
        @(negedge clk);
        check("pre_rst_valid", {31'b0, imem_bus.imem_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_imem_valid", {31'b0, imem_bus.imem_valid}, 32'h0);
        check("arst_pc",         PC,       32'h0);
        check("arst_instr",      instr,    32'h0000_0013);
        check("arst_bad_addr",   bad_addr, 32'h0);
        check("arst_instret",    instret,  32'h0);
        check("arst_ivalid",     {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_bus.imem_ready = 1'b1;
        @(negedge clk);
        check("rerun_valid", {31'b0, imem_bus.imem_valid}, 32'h1);
        check("rerun_addr",  imem_bus.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
